// File: rtl/dense_layer_engine.sv
// Serial dense-layer engine: one neuron at a time, bias + sum(in*w), saturated into a dual-port output RAM.
// Optional macro DENSE_LAYER_ENGINE_RELU_EN clamps negative stored results to zero.
module dense_layer_engine #(
  parameter int  DATA_W    = 32,
  parameter int  FRAC_W    = 16,
  parameter int  IN_COUNT  = 10,
  parameter int  OUT_COUNT = 3,
  localparam int IN_AW     = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1,
  localparam int OUT_AW    = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1,
  localparam int W_AW      = (IN_COUNT * OUT_COUNT > 1) ? $clog2(IN_COUNT * OUT_COUNT) : 1,
  localparam int ACC_W     = 2 * DATA_W + IN_AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [IN_AW-1:0]  in_adr,
  input  logic [DATA_W-1:0] in_data,
  output logic [W_AW-1:0]   weight_adr,
  input  logic [DATA_W-1:0] weight_data,
  output logic [OUT_AW-1:0] bias_adr,
  input  logic [DATA_W-1:0] bias_data,
  input  logic [OUT_AW-1:0] rd_adr,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_WRITE, S_DONE} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                   state_q, state_d;
  logic                     last_in, last_out;
  logic                     acc_en, acc_first;
  logic signed [ACC_W-1:0]  acc, prod_ext, bias_ext, shifted;
  logic signed [DATA_W-1:0] in_s, w_s, b_s;
  logic        [DATA_W-1:0] sat_val, wr_val;
  logic        [DATA_W-1:0] out_ram [OUT_COUNT];

  assign last_in  = (in_adr == IN_AW'(IN_COUNT - 1));
  assign last_out = (bias_adr == OUT_AW'(OUT_COUNT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MAC;
      S_MAC:   if (last_in) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = last_out ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_MAC) || (state_q == S_DRAIN) || (state_q == S_WRITE);
  assign done = (state_q == S_DONE);

  // Memory data arrives one cycle after its address, so products are sign-extended to ACC_W and summed then.
  assign in_s     = in_data;
  assign w_s      = weight_data;
  assign b_s      = bias_data;
  assign prod_ext = ACC_W'(in_s) * ACC_W'(w_s);
  assign bias_ext = ACC_W'(b_s) <<< FRAC_W;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_adr     <= '0;
      weight_adr <= '0;
      bias_adr   <= '0;
      out_valid  <= 1'b0;
      acc_en     <= 1'b0;
      acc_first  <= 1'b0;
      acc        <= '0;
    end else begin
      acc_en    <= (state_q == S_MAC);
      acc_first <= (state_q == S_MAC) && (in_adr == '0);
      if (acc_en) acc <= acc_first ? (bias_ext + prod_ext) : (acc + prod_ext);
      case (state_q)
        S_IDLE: if (start) begin
          in_adr     <= '0;
          weight_adr <= '0;
          bias_adr   <= '0;
          out_valid  <= 1'b0;
        end
        S_MAC: if (!last_in) begin
          in_adr     <= in_adr + IN_AW'(1);
          weight_adr <= weight_adr + W_AW'(1);
        end
        // Weights are row-major, so the next neuron's row starts right after the current one.
        S_WRITE: if (!last_out) begin
          in_adr     <= '0;
          weight_adr <= weight_adr + W_AW'(1);
          bias_adr   <= bias_adr + OUT_AW'(1);
        end
        S_DONE:  out_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  assign shifted = acc >>> FRAC_W;

  always_comb begin
    sat_val = shifted[DATA_W-1:0];
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
  end

`ifdef DENSE_LAYER_ENGINE_RELU_EN
  assign wr_val = sat_val[DATA_W-1] ? '0 : sat_val;
`else
  assign wr_val = sat_val;
`endif

  // NOTE: the RAM array is deliberately not reset; results survive reset and map onto block RAM.
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE) out_ram[bias_adr] <= wr_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         rd_data <= '0;
    else if (int'(rd_adr) < OUT_COUNT) rd_data <= out_ram[rd_adr];
    else                              rd_data <= '0;
  end

endmodule
